pito_mem_xbar: RTL and testbench
================================

// Module: pito_mem_xbar
// PURPOSE
//  Parametrised memory interconnect replacing the fixed two-port ext/core hookup of the SoC memories.
//  NumMasters requesters (core imem/dmem, external loader, MVU ...) reach NumBanks word-interleaved
//  single-port SRAM banks plus one MMIO window (UART and later peripherals).
//  Per-target round-robin arbitration, fixed-latency bank responses, variable-latency MMIO responses,
//  and in-order responses per master.
// PARAMETERS
//  NumMasters      2     requesting ports, >=1
//  NumBanks        2     SRAM banks, power of two, >=1
//  AddrWidth       32    byte address width
//  DataWidth       32    data width; BE width = DataWidth/8
//  BankWords       2048  words per bank; row index = word_addr>>log2(NumBanks), truncated modulo BankWords
//  Latency         1     bank read latency in cycles, >=1
//  MmioBit         31    addr[MmioBit]==1 selects the MMIO window
//  MmioOutstanding 2     max MMIO requests in flight
// PORTS
//  clk          in   1              clock
//  rst_n        in   1              async active-low reset
//  m_req        in   NumMasters     request valid per master
//  m_gnt        out  NumMasters     request accepted this cycle
//  m_we         in   NumMasters     1 = write
//  m_addr       in   NM x AddrWidth byte address
//  m_wdata      in   NM x DataWidth write data
//  m_be         in   NM x DW/8      byte enables
//  m_rvalid     out  NumMasters     response valid (reads and writes)
//  m_rdata      out  NM x DataWidth read data, valid with m_rvalid
//  bank_req     out  NumBanks       bank access strobe
//  bank_we      out  NumBanks       bank write enable
//  bank_addr    out  NB x log2(BankWords) bank row
//  bank_wdata   out  NB x DataWidth ; bank_be out NB x DW/8
//  bank_rdata   in   NB x DataWidth valid Latency cycles after bank_req
//  mmio_req     out  1              MMIO request valid
//  mmio_gnt     in   1              MMIO target accepts (req && gnt = transfer)
//  mmio_we/addr/wdata/be  out       as m_* for the granted master
//  mmio_rvalid  in   1              MMIO response, exactly one per transfer, in order
//  mmio_rdata   in   DataWidth      MMIO read data
//  err          out  1              sticky: mmio_rvalid with no MMIO request in flight
// BEHAVIOUR
//  Reset: all outputs 0, RR pointers 0, pipelines/FIFO/counters cleared; in-flight responses are dropped.
//  Decode: addr[MmioBit]=1 -> MMIO; else bank = word_addr[log2NB-1:0], row = word_addr>>log2NB.
//  Arbitration per target, combinational, same cycle: eligible requesters for a target are scanned from
//   ptr upward (wrapping); first wins; on grant ptr <= winner+1 mod NumMasters; no grant -> ptr held.
//  Each master holds at most one grant per cycle (single address); a request stays asserted until m_gnt.
//  Bank path: bank_req/we/addr/wdata/be driven combinationally from the winner; the master ID and valid
//   enter a Latency-deep shift register; m_rvalid[id] asserted exactly Latency cycles after m_gnt,
//   m_rdata = bank_rdata of that bank. Writes also return m_rvalid (rdata don't-care).
//  MMIO path: mmio_req = any eligible MMIO requester; grant only when mmio_gnt=1 and ID FIFO not full
//   (depth MmioOutstanding). On mmio_rvalid pop FIFO head -> m_rvalid[head] with mmio_rdata, same cycle
//   (combinational). FIFO empty at mmio_rvalid -> response dropped, err <= 1.
//  Ordering: per-master counters of bank and MMIO responses in flight. Master not eligible for a bank
//   target while it has MMIO in flight, nor for MMIO while it has bank in flight; guarantees in-order
//   responses and no m_rvalid collision.
//  Simultaneous FIFO push and pop allowed, including when full (pop frees the slot the same cycle).
//  Counters sized to hold Latency and MmioOutstanding; they never wrap by construction.
// STRUCTURE
//  pito_pkg: PITO_XBAR_* default constants, xbar_req_t/xbar_rsp_t structs (we, addr, wdata, be / rdata).
//  Sub-module pito_rr_arbiter (NumReq param; req vector in, one-hot gnt out, pointer reg), one per bank
//   and one for MMIO. MMIO ID FIFO and bank shift registers are inline.
// TESTING
//  NM=2,NB=2: M0 rd 0x0, M1 rd 0x4 same cycle -> both gnt, bank0/bank1, both rvalid at +Latency.
//  Both read 0x8 continuously -> gnt alternates M0,M1,M0... ; each rvalid Latency cycles after its gnt.
//  M0 wr 0x8000_0000 with mmio_gnt held 0 for 3 cycles -> m_gnt[0] only in cycle mmio_gnt=1; rvalid on mmio_rvalid.
//  3 MMIO reqs, mmio_rvalid held 0 -> first 2 granted, 3rd stalls until first response (push+pop same cycle).
//  M0 MMIO in flight then M0 bank rd -> bank gnt withheld until MMIO rvalid; responses arrive in order.
//  rst_n low with Latency=3 reads in flight -> no m_rvalid after release; mmio_rvalid on empty FIFO -> err=1.

Source files
------------

// File: rtl/pito_pkg.sv
// Shared defaults, request/response records and helpers for the pito memory crossbar.
package pito_pkg;

    localparam int unsigned PITO_XBAR_NUM_MASTERS     = 2;
    localparam int unsigned PITO_XBAR_NUM_BANKS       = 2;
    localparam int unsigned PITO_XBAR_ADDR_WIDTH      = 32;
    localparam int unsigned PITO_XBAR_DATA_WIDTH      = 32;
    localparam int unsigned PITO_XBAR_BANK_WORDS      = 2048;
    localparam int unsigned PITO_XBAR_LATENCY         = 1;
    localparam int unsigned PITO_XBAR_MMIO_BIT        = 31;
    localparam int unsigned PITO_XBAR_MMIO_OUTSTANDING = 2;

    // One master-side request at the default widths.
    typedef struct packed {
        logic                                  we;
        logic [PITO_XBAR_ADDR_WIDTH-1:0]       addr;
        logic [PITO_XBAR_DATA_WIDTH-1:0]       wdata;
        logic [PITO_XBAR_DATA_WIDTH/8-1:0]     be;
    } xbar_req_t;

    // One master-side response at the default widths.
    typedef struct packed {
        logic [PITO_XBAR_DATA_WIDTH-1:0]       rdata;
    } xbar_rsp_t;

    // Width of an index into n items; never below one bit.
    function automatic int unsigned pito_idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pito_rr_arbiter.sv
// Round-robin arbiter: scans from the pointer upward, one-hot pick, pointer advances past an accepted winner.
module pito_rr_arbiter
    import pito_pkg::*;
#(
    parameter int unsigned NumReq = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NumReq-1:0] req,
    input  logic              ack,
    output logic [NumReq-1:0] gnt
);

    localparam int unsigned PtrW = pito_idx_width(NumReq);

    logic [PtrW-1:0] ptr;
    logic [PtrW-1:0] win;
    logic            found;
    int unsigned     idx;

    // Pick the first requester at or above the pointer, wrapping around.
    always_comb begin
        gnt   = '0;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            idx = (32'(ptr) + k) % NumReq;
            if (!found && req[idx]) begin
                found    = 1'b1;
                win      = PtrW'(idx);
                gnt[idx] = 1'b1;
            end
        end
    end

    // Move the pointer one past the winner only when the target took the request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (ack && found) begin
            ptr <= (win == PtrW'(NumReq - 1)) ? '0 : win + PtrW'(1);
        end
    end

endmodule

// File: rtl/pito_mem_xbar.sv
// Memory crossbar: NumMasters requesters onto word-interleaved SRAM banks plus one MMIO window.
module pito_mem_xbar
    import pito_pkg::*;
#(
    parameter int unsigned NumMasters      = PITO_XBAR_NUM_MASTERS,
    parameter int unsigned NumBanks        = PITO_XBAR_NUM_BANKS,
    parameter int unsigned AddrWidth       = PITO_XBAR_ADDR_WIDTH,
    parameter int unsigned DataWidth       = PITO_XBAR_DATA_WIDTH,
    parameter int unsigned BankWords       = PITO_XBAR_BANK_WORDS,
    parameter int unsigned Latency         = PITO_XBAR_LATENCY,
    parameter int unsigned MmioBit         = PITO_XBAR_MMIO_BIT,
    parameter int unsigned MmioOutstanding = PITO_XBAR_MMIO_OUTSTANDING
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [NumMasters-1:0]                       m_req,
    output logic [NumMasters-1:0]                       m_gnt,
    input  logic [NumMasters-1:0]                       m_we,
    input  logic [NumMasters-1:0][AddrWidth-1:0]        m_addr,
    input  logic [NumMasters-1:0][DataWidth-1:0]        m_wdata,
    input  logic [NumMasters-1:0][DataWidth/8-1:0]      m_be,
    output logic [NumMasters-1:0]                       m_rvalid,
    output logic [NumMasters-1:0][DataWidth-1:0]        m_rdata,
    output logic [NumBanks-1:0]                         bank_req,
    output logic [NumBanks-1:0]                         bank_we,
    output logic [NumBanks-1:0][$clog2(BankWords)-1:0]  bank_addr,
    output logic [NumBanks-1:0][DataWidth-1:0]          bank_wdata,
    output logic [NumBanks-1:0][DataWidth/8-1:0]        bank_be,
    input  logic [NumBanks-1:0][DataWidth-1:0]          bank_rdata,
    output logic                                        mmio_req,
    input  logic                                        mmio_gnt,
    output logic                                        mmio_we,
    output logic [AddrWidth-1:0]                        mmio_addr,
    output logic [DataWidth-1:0]                        mmio_wdata,
    output logic [DataWidth/8-1:0]                      mmio_be,
    input  logic                                        mmio_rvalid,
    input  logic [DataWidth-1:0]                        mmio_rdata,
    output logic                                        err
);

    localparam int unsigned BeW      = DataWidth / 8;
    localparam int unsigned RowW     = $clog2(BankWords);
    localparam int unsigned BankBits = $clog2(NumBanks);
    localparam int unsigned BankSelW = pito_idx_width(NumBanks);
    localparam int unsigned OffBits  = $clog2(BeW);
    localparam int unsigned IdW      = pito_idx_width(NumMasters);
    localparam int unsigned BCntW    = $clog2(Latency + 1);
    localparam int unsigned MCntW    = $clog2(MmioOutstanding + 1);
    localparam int unsigned FPtrW    = pito_idx_width(MmioOutstanding);

    logic [NumMasters-1:0]                  is_mmio;
    logic [NumMasters-1:0][AddrWidth-1:0]   word_addr;
    logic [NumMasters-1:0][BankSelW-1:0]    bank_of;
    logic [NumMasters-1:0][RowW-1:0]        row_of;

    logic [NumBanks-1:0][NumMasters-1:0]    bank_elig;
    logic [NumBanks-1:0][NumMasters-1:0]    bank_pick;
    logic [NumBanks-1:0][IdW-1:0]           bank_id;
    logic [NumMasters-1:0]                  mmio_elig;
    logic [NumMasters-1:0]                  mmio_pick;
    logic [IdW-1:0]                         mmio_id;

    logic [NumMasters-1:0][BCntW-1:0]       bank_cnt;
    logic [NumMasters-1:0][MCntW-1:0]       mmio_cnt;
    logic [NumMasters-1:0]                  bank_issue;
    logic [NumMasters-1:0]                  mmio_issue;
    logic [NumMasters-1:0]                  bank_rsp;
    logic [NumMasters-1:0]                  mmio_rsp;

    logic [NumBanks-1:0][Latency-1:0]           pipe_v;
    logic [NumBanks-1:0][Latency-1:0][IdW-1:0]  pipe_id;

    logic [MmioOutstanding-1:0][IdW-1:0]    fifo_mem;
    logic [FPtrW-1:0]                       wr_ptr;
    logic [FPtrW-1:0]                       rd_ptr;
    logic [MCntW-1:0]                       fifo_cnt;
    logic                                   fifo_pop;
    logic                                   mmio_room;
    logic                                   mmio_accept;

    // Decode each master address into MMIO flag, bank index and bank row.
    always_comb begin
        is_mmio   = '0;
        word_addr = '0;
        bank_of   = '0;
        row_of    = '0;
        for (int unsigned m = 0; m < NumMasters; m++) begin
            is_mmio[m]   = m_addr[m][MmioBit];
            word_addr[m] = m_addr[m] >> OffBits;
            bank_of[m]   = BankSelW'(word_addr[m] & AddrWidth'(NumBanks - 1));
            row_of[m]    = RowW'(word_addr[m] >> BankBits);
        end
    end

    // A master may only target the path it already has responses pending on, keeping its responses in order.
    always_comb begin
        bank_elig = '0;
        mmio_elig = '0;
        for (int unsigned m = 0; m < NumMasters; m++) begin
            if (m_req[m]) begin
                if (is_mmio[m]) begin
                    if (bank_cnt[m] == '0) mmio_elig[m] = 1'b1;
                end else if (mmio_cnt[m] == '0) begin
                    for (int unsigned b = 0; b < NumBanks; b++) begin
                        if (bank_of[m] == BankSelW'(b)) bank_elig[b][m] = 1'b1;
                    end
                end
            end
        end
    end

    for (genvar b = 0; b < NumBanks; b++) begin : g_bank_arb
        pito_rr_arbiter #(.NumReq(NumMasters)) u_arb (
            .clk   (clk),
            .rst_n (rst_n),
            .req   (bank_elig[b]),
            .ack   (1'b1),
            .gnt   (bank_pick[b])
        );
    end

    pito_rr_arbiter #(.NumReq(NumMasters)) u_mmio_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (mmio_elig),
        .ack   (mmio_accept),
        .gnt   (mmio_pick)
    );

    // A response popping this cycle frees a slot, so a full FIFO can still accept.
    assign fifo_pop    = mmio_rvalid && (fifo_cnt != '0);
    assign mmio_room   = (fifo_cnt != MCntW'(MmioOutstanding)) || fifo_pop;
    // Request is withheld while no ID slot is free so that every req&&gnt transfer is tracked.
    assign mmio_req    = (|mmio_elig) && mmio_room;
    assign mmio_accept = mmio_req && mmio_gnt;

    // Route arbitration winners onto the bank and MMIO ports and raise the matching master grants.
    always_comb begin
        m_gnt      = '0;
        bank_req   = '0;
        bank_we    = '0;
        bank_addr  = '0;
        bank_wdata = '0;
        bank_be    = '0;
        bank_id    = '0;
        bank_issue = '0;
        mmio_issue = '0;
        mmio_we    = 1'b0;
        mmio_addr  = '0;
        mmio_wdata = '0;
        mmio_be    = '0;
        mmio_id    = '0;
        for (int unsigned b = 0; b < NumBanks; b++) begin
            for (int unsigned m = 0; m < NumMasters; m++) begin
                if (bank_pick[b][m]) begin
                    bank_req[b]   = 1'b1;
                    bank_we[b]    = m_we[m];
                    bank_addr[b]  = row_of[m];
                    bank_wdata[b] = m_wdata[m];
                    bank_be[b]    = m_be[m];
                    bank_id[b]    = IdW'(m);
                    m_gnt[m]      = 1'b1;
                    bank_issue[m] = 1'b1;
                end
            end
        end
        for (int unsigned m = 0; m < NumMasters; m++) begin
            if (mmio_pick[m]) begin
                mmio_we    = m_we[m];
                mmio_addr  = m_addr[m];
                mmio_wdata = m_wdata[m];
                mmio_be    = m_be[m];
                mmio_id    = IdW'(m);
                if (mmio_accept) begin
                    m_gnt[m]      = 1'b1;
                    mmio_issue[m] = 1'b1;
                end
            end
        end
    end

    // Carry the granted master ID alongside each bank access for Latency cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v  <= '0;
            pipe_id <= '0;
        end else begin
            for (int unsigned b = 0; b < NumBanks; b++) begin
                pipe_v[b][0]  <= bank_req[b];
                pipe_id[b][0] <= bank_id[b];
                for (int unsigned s = 1; s < Latency; s++) begin
                    pipe_v[b][s]  <= pipe_v[b][s-1];
                    pipe_id[b][s] <= pipe_id[b][s-1];
                end
            end
        end
    end

    // In-order MMIO ID FIFO plus the sticky error for responses nobody asked for.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (mmio_accept) begin
                fifo_mem[wr_ptr] <= mmio_id;
                wr_ptr <= (wr_ptr == FPtrW'(MmioOutstanding - 1)) ? '0 : wr_ptr + FPtrW'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= (rd_ptr == FPtrW'(MmioOutstanding - 1)) ? '0 : rd_ptr + FPtrW'(1);
            end
            fifo_cnt <= fifo_cnt + MCntW'(mmio_accept) - MCntW'(fifo_pop);
            if (mmio_rvalid && (fifo_cnt == '0)) err <= 1'b1;
        end
    end

    // Steer bank pipeline outputs and the MMIO response back to the owning master.
    always_comb begin
        m_rvalid = '0;
        m_rdata  = '0;
        bank_rsp = '0;
        mmio_rsp = '0;
        for (int unsigned b = 0; b < NumBanks; b++) begin
            if (pipe_v[b][Latency-1]) begin
                for (int unsigned m = 0; m < NumMasters; m++) begin
                    if (pipe_id[b][Latency-1] == IdW'(m)) begin
                        m_rvalid[m] = 1'b1;
                        m_rdata[m]  = bank_rdata[b];
                        bank_rsp[m] = 1'b1;
                    end
                end
            end
        end
        if (fifo_pop) begin
            for (int unsigned m = 0; m < NumMasters; m++) begin
                if (fifo_mem[rd_ptr] == IdW'(m)) begin
                    m_rvalid[m] = 1'b1;
                    m_rdata[m]  = mmio_rdata;
                    mmio_rsp[m] = 1'b1;
                end
            end
        end
    end

    // Track per-master responses in flight on each path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_cnt <= '0;
            mmio_cnt <= '0;
        end else begin
            for (int unsigned m = 0; m < NumMasters; m++) begin
                bank_cnt[m] <= bank_cnt[m] + BCntW'(bank_issue[m]) - BCntW'(bank_rsp[m]);
                mmio_cnt[m] <= mmio_cnt[m] + MCntW'(mmio_issue[m]) - MCntW'(mmio_rsp[m]);
            end
        end
    end

endmodule

// File: tb/tb_pito_mem_xbar.sv
// Directed scoreboard bench for pito_mem_xbar with two masters, two banks and a 3-cycle bank latency.
module tb_pito_mem_xbar;
    import pito_pkg::*;

    localparam int unsigned NM   = 2;
    localparam int unsigned NB   = 2;
    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned BW   = 2048;
    localparam int unsigned LAT  = 3;
    localparam int unsigned MO   = 2;
    localparam int unsigned RowW = $clog2(BW);

    logic                         clk;
    logic                         rst_n;
    logic [NM-1:0]                m_req;
    logic [NM-1:0]                m_gnt;
    logic [NM-1:0]                m_we;
    logic [NM-1:0][AW-1:0]        m_addr;
    logic [NM-1:0][DW-1:0]        m_wdata;
    logic [NM-1:0][DW/8-1:0]      m_be;
    logic [NM-1:0]                m_rvalid;
    logic [NM-1:0][DW-1:0]        m_rdata;
    logic [NB-1:0]                bank_req;
    logic [NB-1:0]                bank_we;
    logic [NB-1:0][RowW-1:0]      bank_addr;
    logic [NB-1:0][DW-1:0]        bank_wdata;
    logic [NB-1:0][DW/8-1:0]      bank_be;
    logic [NB-1:0][DW-1:0]        bank_rdata;
    logic                         mmio_req;
    logic                         mmio_gnt;
    logic                         mmio_we;
    logic [AW-1:0]                mmio_addr;
    logic [DW-1:0]                mmio_wdata;
    logic [DW/8-1:0]              mmio_be;
    logic                         mmio_rvalid;
    logic [DW-1:0]                mmio_rdata;
    logic                         err;

    pito_mem_xbar #(
        .NumMasters      (NM),
        .NumBanks        (NB),
        .AddrWidth       (AW),
        .DataWidth       (DW),
        .BankWords       (BW),
        .Latency         (LAT),
        .MmioBit         (31),
        .MmioOutstanding (MO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m_req       (m_req),
        .m_gnt       (m_gnt),
        .m_we        (m_we),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_be        (m_be),
        .m_rvalid    (m_rvalid),
        .m_rdata     (m_rdata),
        .bank_req    (bank_req),
        .bank_we     (bank_we),
        .bank_addr   (bank_addr),
        .bank_wdata  (bank_wdata),
        .bank_be     (bank_be),
        .bank_rdata  (bank_rdata),
        .mmio_req    (mmio_req),
        .mmio_gnt    (mmio_gnt),
        .mmio_we     (mmio_we),
        .mmio_addr   (mmio_addr),
        .mmio_wdata  (mmio_wdata),
        .mmio_be     (mmio_be),
        .mmio_rvalid (mmio_rvalid),
        .mmio_rdata  (mmio_rdata),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic          chk_data;
        int            cycle;
    } exp_t;

    exp_t exp_q [NM][$];

    // Bank SRAM model: row r of bank b starts as 0xB000_0000 | b<<16 | r; data appears LAT cycles after bank_req.
    logic [DW-1:0] mem     [NB][16];
    logic [DW-1:0] rd_pipe [NB][LAT];
    logic          mem_loaded = 1'b0;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                            input logic [DW/8-1:0] be);
        logic [DW-1:0] r;
        r = old_w;
        for (int i = 0; i < DW/8; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    // Memory and read pipeline of the bank model.
    always @(posedge clk) begin
        if (!mem_loaded) begin
            mem_loaded <= 1'b1;
            for (int b = 0; b < NB; b++)
                for (int r = 0; r < 16; r++)
                    mem[b][r] <= 32'hB000_0000 | (32'(b) << 16) | 32'(r);
        end
        for (int b = 0; b < NB; b++) begin
            if (bank_req[b]) begin
                rd_pipe[b][0] <= mem[b][bank_addr[b][3:0]];
                if (bank_we[b]) mem[b][bank_addr[b][3:0]] <= merge(mem[b][bank_addr[b][3:0]], bank_wdata[b], bank_be[b]);
            end else begin
                rd_pipe[b][0] <= 32'hDEAD_0000;
            end
            for (int s = 1; s < LAT; s++) rd_pipe[b][s] <= rd_pipe[b][s-1];
        end
    end

    // Bank read data seen by the DUT.
    always_comb begin
        bank_rdata = '0;
        for (int b = 0; b < NB; b++) bank_rdata[b] = rd_pipe[b][LAT-1];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int m, input logic [DW-1:0] data, input logic chk_data, input int cycle);
        exp_t e;
        e.data     = data;
        e.chk_data = chk_data;
        e.cycle    = cycle;
        exp_q[m].push_back(e);
    endtask

    // Monitor: every m_rvalid pops that master's oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int m = 0; m < NM; m++) begin
                if (m_rvalid[m]) begin
                    if (exp_q[m].size() == 0) begin
                        chk($sformatf("spurious_rvalid_m%0d", m), 64'(m_rvalid[m]), 64'd0);
                    end else begin
                        e = exp_q[m].pop_front();
                        if (e.chk_data) chk($sformatf("rdata_m%0d", m), 64'(m_rdata[m]), 64'(e.data));
                        if (e.cycle >= 0) chk($sformatf("rsp_cycle_m%0d", m), 64'(cyc), 64'(e.cycle));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int m, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [DW/8-1:0] be);
        m_req[m]   = 1'b1;
        m_we[m]    = we;
        m_addr[m]  = addr;
        m_wdata[m] = wdata;
        m_be[m]    = be;
    endtask

    task automatic clr_req(input int m);
        m_req[m]   = 1'b0;
        m_we[m]    = 1'b0;
        m_addr[m]  = '0;
        m_wdata[m] = '0;
        m_be[m]    = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Watchdog against a hung run.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic got;
        m_req       = '0;
        m_we        = '0;
        m_addr      = '0;
        m_wdata     = '0;
        m_be        = '0;
        mmio_gnt    = 1'b0;
        mmio_rvalid = 1'b0;
        mmio_rdata  = '0;
        rst_n       = 1'b0;

        // Reset state
        idle(3);
        @(negedge clk);
        chk("rst_m_gnt", 64'(m_gnt), 64'd0);
        chk("rst_m_rvalid", 64'(m_rvalid), 64'd0);
        chk("rst_bank_req", 64'(bank_req), 64'd0);
        chk("rst_mmio_req", 64'(mmio_req), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        tick();
        rst_n = 1'b1;
        idle(2);

        // Same-cycle reads to different banks
        set_req(0, 1'b0, 32'h0000_0000, '0, 4'hF);
        set_req(1, 1'b0, 32'h0000_0004, '0, 4'hF);
        @(negedge clk);
        chk("t1_gnt", 64'(m_gnt), 64'b11);
        chk("t1_bank_req", 64'(bank_req), 64'b11);
        push(0, 32'hB000_0000, 1'b1, cyc + LAT);
        push(1, 32'hB001_0000, 1'b1, cyc + LAT);
        tick();
        clr_req(0);
        clr_req(1);
        idle(LAT + 2);

        // Both masters hammer bank0 row1; bank0 pointer sits at 1 after M0's win above
        set_req(0, 1'b0, 32'h0000_0008, '0, 4'hF);
        set_req(1, 1'b0, 32'h0000_0008, '0, 4'hF);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("t2_gnt_%0d", k), 64'(m_gnt), (k % 2 == 0) ? 64'b10 : 64'b01);
            push((k % 2 == 0) ? 1 : 0, 32'hB000_0001, 1'b1, cyc + LAT);
            tick();
        end
        clr_req(0);
        clr_req(1);
        idle(LAT + 2);

        // Partial write to bank1 row1 then read it back
        set_req(1, 1'b1, 32'h0000_000C, 32'hDEAD_BEEF, 4'b0011);
        @(negedge clk);
        chk("t2b_wr_gnt", 64'(m_gnt), 64'b10);
        chk("t2b_bank_we", 64'(bank_we), 64'b10);
        chk("t2b_bank_addr", 64'(bank_addr[1]), 64'd1);
        push(1, '0, 1'b0, cyc + LAT);
        tick();
        clr_req(1);
        set_req(0, 1'b0, 32'h0000_000C, '0, 4'hF);
        @(negedge clk);
        chk("t2b_rd_gnt", 64'(m_gnt), 64'b01);
        push(0, 32'hB001_BEEF, 1'b1, cyc + LAT);
        tick();
        clr_req(0);
        idle(LAT + 2);

        // MMIO write with the target stalling for three cycles
        set_req(0, 1'b1, 32'h8000_0000, 32'h1234_5678, 4'hF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("t3_stall_gnt_%0d", k), 64'(m_gnt), 64'd0);
            chk($sformatf("t3_stall_req_%0d", k), 64'(mmio_req), 64'd1);
            tick();
        end
        mmio_gnt = 1'b1;
        @(negedge clk);
        chk("t3_gnt", 64'(m_gnt), 64'b01);
        chk("t3_mmio_addr", 64'(mmio_addr), 64'h8000_0000);
        chk("t3_mmio_we", 64'(mmio_we), 64'd1);
        chk("t3_mmio_wdata", 64'(mmio_wdata), 64'h1234_5678);
        push(0, '0, 1'b0, -1);
        tick();
        clr_req(0);
        mmio_gnt = 1'b0;
        tick();
        mmio_rvalid = 1'b1;
        mmio_rdata  = 32'h0000_0000;
        tick();
        mmio_rvalid = 1'b0;
        idle(2);

        // Three MMIO reads against a two-deep ID FIFO; MMIO pointer is at 1 after M0's win
        mmio_gnt = 1'b1;
        set_req(0, 1'b0, 32'h8000_0010, '0, 4'hF);
        set_req(1, 1'b0, 32'h8000_0014, '0, 4'hF);
        @(negedge clk);
        chk("t4_gnt_c1", 64'(m_gnt), 64'b10);
        push(1, 32'h0000_AAAA, 1'b1, -1);
        tick();
        set_req(1, 1'b0, 32'h8000_0018, '0, 4'hF);
        @(negedge clk);
        chk("t4_gnt_c2", 64'(m_gnt), 64'b01);
        push(0, 32'h0000_BBBB, 1'b1, -1);
        tick();
        clr_req(0);
        @(negedge clk);
        chk("t4_full_c3", 64'(m_gnt), 64'd0);
        tick();
        @(negedge clk);
        chk("t4_full_c4", 64'(m_gnt), 64'd0);
        tick();
        mmio_rvalid = 1'b1;
        mmio_rdata  = 32'h0000_AAAA;
        @(negedge clk);
        chk("t4_pushpop_gnt", 64'(m_gnt), 64'b10);
        push(1, 32'h0000_CCCC, 1'b1, -1);
        tick();
        clr_req(1);
        mmio_rdata = 32'h0000_BBBB;
        tick();
        mmio_rdata = 32'h0000_CCCC;
        tick();
        mmio_rvalid = 1'b0;
        mmio_rdata  = '0;
        idle(2);

        // Bank read held back while the same master's MMIO read is outstanding
        set_req(0, 1'b0, 32'h8000_0020, '0, 4'hF);
        @(negedge clk);
        chk("t5_mmio_gnt", 64'(m_gnt), 64'b01);
        push(0, 32'h0000_5555, 1'b1, -1);
        tick();
        set_req(0, 1'b0, 32'h0000_0000, '0, 4'hF);
        @(negedge clk);
        chk("t5_withheld_c2", 64'(m_gnt), 64'd0);
        tick();
        @(negedge clk);
        chk("t5_withheld_c3", 64'(m_gnt), 64'd0);
        tick();
        mmio_rvalid = 1'b1;
        mmio_rdata  = 32'h0000_5555;
        tick();
        mmio_rvalid = 1'b0;
        mmio_rdata  = '0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (m_gnt[0]) begin
                got = 1'b1;
                push(0, 32'hB000_0000, 1'b1, cyc + LAT);
            end
            tick();
        end
        chk("t5_bank_gnt_seen", 64'(got), 64'd1);
        clr_req(0);
        mmio_gnt = 1'b0;
        idle(LAT + 2);

        // Reset while bank reads are in flight drops them
        set_req(0, 1'b0, 32'h0000_0000, '0, 4'hF);
        set_req(1, 1'b0, 32'h0000_0004, '0, 4'hF);
        @(negedge clk);
        chk("t6_gnt", 64'(m_gnt), 64'b11);
        tick();
        clr_req(0);
        clr_req(1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rvalid_in_rst", 64'(m_rvalid), 64'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < LAT + 3; k++) begin
            @(negedge clk);
            chk($sformatf("t6_no_rvalid_%0d", k), 64'(m_rvalid), 64'd0);
            tick();
        end

        // Response with no MMIO request in flight sets the sticky error
        chk("t6_err_before", 64'(err), 64'd0);
        mmio_rvalid = 1'b1;
        mmio_rdata  = 32'h0BAD_0BAD;
        @(negedge clk);
        chk("t6_orphan_rvalid", 64'(m_rvalid), 64'd0);
        tick();
        mmio_rvalid = 1'b0;
        mmio_rdata  = '0;
        @(negedge clk);
        chk("t6_err_set", 64'(err), 64'd1);
        tick();
        idle(2);
        @(negedge clk);
        chk("t6_err_sticky", 64'(err), 64'd1);

        // Every expected response must have arrived
        for (int i = 0; i < 50 && (exp_q[0].size() != 0 || exp_q[1].size() != 0); i++) @(negedge clk);
        chk("drain_m0", 64'(exp_q[0].size()), 64'd0);
        chk("drain_m1", 64'(exp_q[1].size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
